// File: rtl/data_memory_controller_pkg.sv
// Shared load/store control encodings and controller state codes; also used by the decoder.
// Pure definitions: no latency, no flow control.
package data_memory_controller_pkg;

    localparam int RD_EN_BIT  = 3;
    localparam int RD_F3_MSB  = 2;
    localparam int WR_EN_BIT  = 2;
    localparam int WR_SZ_MSB  = 1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // Undefined load funct3 codes collapse onto word size.
    function automatic logic [1:0] ld_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   ld_size = SZ_BYTE;
            2'b01:   ld_size = SZ_HALF;
            default: ld_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_memory_controller_lane_align.sv
// Store lane steering / byte enables and load lane select with sign or zero extension.
// Purely combinational (0 cycles); no flow control of its own.
module mem_lane_align
    import data_memory_controller_pkg::*;
(
    input  logic        i_is_write,
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_byteen,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_data = i_st_data;
        o_byteen  = 4'b1111;
        if (i_is_write) begin
            case (i_st_size)
                SZ_BYTE: begin
                    o_st_data = {4{i_st_data[7:0]}};
                    o_byteen  = 4'b0001 << i_st_addr_lo;
                end
                SZ_HALF: begin
                    o_st_data = {2{i_st_data[15:0]}};
                    o_byteen  = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    o_st_data = i_st_data;
                    o_byteen  = 4'b1111;
                end
            endcase
        end
    end

    assign w_byte = i_ld_word[{i_ld_addr_lo, 3'b000} +: 8];
    assign w_half = i_ld_word[{i_ld_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_ld_data = {24'h0, w_byte};
            F3_LHU:  o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// MEM-stage controller: one handshaked word access per request, 2+ cycles, ack or timeout ends it.
// BUSYWAIT stalls the pipeline from the request cycle until the one-cycle DONE window.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  READ_CTRL,
    input  logic [2:0]  WRITE_CTRL,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        TIMEOUT_ERR,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [29:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTEEN,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_ACK
);

    localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_is_write;
    logic [2:0]    r_funct3;
    logic [1:0]    r_addr_lo;
    logic [31:0]   r_read_data;
    logic          r_misaligned;
    logic          r_timeout;
    logic          r_mem_read;
    logic          r_mem_write;
    logic [29:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_byteen;

    logic          w_wr;
    logic          w_req;
    logic [1:0]    w_size;
    logic          w_misaligned;
    logic [31:0]   w_st_data;
    logic [3:0]    w_byteen;
    logic [31:0]   w_ld_data;

    // A store beats a simultaneous load.
    assign w_wr         = WRITE_CTRL[WR_EN_BIT];
    assign w_req        = READ_CTRL[RD_EN_BIT] | w_wr;
    assign w_size       = w_wr ? WRITE_CTRL[WR_SZ_MSB:0] : ld_size(READ_CTRL[RD_F3_MSB:0]);
    assign w_misaligned = is_misaligned(w_size, ADDRESS[1:0]);

    mem_lane_align u_lane_align (
        .i_is_write   (w_wr),
        .i_st_size    (w_size),
        .i_st_addr_lo (ADDRESS[1:0]),
        .i_st_data    (WRITE_DATA),
        .o_st_data    (w_st_data),
        .o_byteen     (w_byteen),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_word    (MEM_READDATA),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_is_write   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr_lo    <= 2'b00;
            r_read_data  <= 32'h0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= 30'h0;
            r_mem_wdata  <= 32'h0;
            r_mem_byteen <= 4'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_misaligned <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_is_write   <= w_wr;
                        r_funct3     <= READ_CTRL[RD_F3_MSB:0];
                        r_addr_lo    <= ADDRESS[1:0];
                        if (w_misaligned) begin
                            r_misaligned <= 1'b1;
                            r_read_data  <= 32'h0;
                            r_state      <= ST_DONE;
                        end else begin
                            r_mem_read   <= ~w_wr;
                            r_mem_write  <= w_wr;
                            r_mem_addr   <= ADDRESS[31:2];
                            r_mem_wdata  <= w_st_data;
                            r_mem_byteen <= w_byteen;
                            r_cnt        <= '0;
                            r_state      <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (MEM_ACK) begin
                        if (!r_is_write) begin
                            r_read_data <= w_ld_data;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_read_data <= 32'h0;
                        r_timeout   <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSYWAIT      = ((r_state == ST_IDLE) && w_req) || (r_state == ST_ACCESS);
    assign READ_DATA     = r_read_data;
    assign MISALIGNED    = r_misaligned;
    assign TIMEOUT_ERR   = r_timeout;
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_addr;
    assign MEM_WRITEDATA = r_mem_wdata;
    assign MEM_BYTEEN    = r_mem_byteen;

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- Responder for the memory-control encodings that the instruction decoder produces.
- Sits in the MEM stage. Takes the per-instruction load/store controls plus the ALU address and store data, and runs one handshaked word access to data memory.
- Steers store bytes onto lanes and sign- or zero-extends load data.
- Holds the pipeline with BUSYWAIT until the access has completed.

Parameters:
- ACK_TIMEOUT, 255: maximum cycles spent waiting for MEM_ACK before the access is abandoned.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ_CTRL  in  4  load control: [3] = read enable, [2:0] = load funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- WRITE_CTRL  in  3  store control: [2] = write enable, [1:0] = size (00 byte, 01 half, 10 word).
- ADDRESS  in  32  byte address from the ALU.
- WRITE_DATA  in  32  store data from rs2.
- READ_DATA  out  32  extended load result, registered.
- BUSYWAIT  out  1  pipeline stall request.
- MISALIGNED  out  1  misaligned access flag, valid while BUSYWAIT=0 at the end of a request.
- TIMEOUT_ERR  out  1  access abandoned flag, valid while BUSYWAIT=0 at the end of a request.
- MEM_READ  out  1  memory read strobe.
- MEM_WRITE  out  1  memory write strobe.
- MEM_ADDRESS  out  30  word address (ADDRESS[31:2]).
- MEM_WRITEDATA  out  32  lane-steered store data.
- MEM_BYTEEN  out  4  byte enables; [0] = bits 7:0 (little-endian).
- MEM_READDATA  in  32  memory read word.
- MEM_ACK  in  1  memory completion, one-cycle pulse.

Behaviour:
- Clocking: single clock domain CLK. RESET is synchronous and active-high; it is sampled on the rising edge.
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - A reset during ACCESS drops MEM_READ/MEM_WRITE at that edge. The abandoned access is not retried.
- Request: req = READ_CTRL[3] | WRITE_CTRL[2].
  - If both enables are set, the write wins and the read is ignored.
- Stall timing:
  - BUSYWAIT = (state==IDLE & req) | (state==ACCESS). It is combinational so the stall holds in the same cycle the request first appears.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On req, register the request fields. Clear MISALIGNED and TIMEOUT_ERR.
  - If the access is aligned, go to ACCESS.
  - If misaligned (half with ADDRESS[0]=1, or word with ADDRESS[1:0]!=0), go to DONE with MISALIGNED=1 and READ_DATA=0. No memory strobe is issued.
- ACCESS:
  - Hold MEM_READ or MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA and MEM_BYTEEN stable from the registered request.
  - A timeout counter starts at 0 on entry and increments each cycle.
  - On MEM_ACK: for loads, register the extended MEM_READDATA into READ_DATA. Drop the strobes and go to DONE.
  - If the counter reaches ACK_TIMEOUT with no ack: drop the strobes, READ_DATA=0, TIMEOUT_ERR=1, go to DONE.
  - MEM_ACK and timeout in the same cycle: the ack wins.
- DONE:
  - BUSYWAIT=0 for exactly one cycle, so the pipeline advances.
  - The still-present request is not re-launched. Next state is IDLE unconditionally.
  - Two back-to-back memory instructions therefore each cost at least 2 cycles of stall.
- Store lane steering:
  - SB: byte replicated across all 4 lanes; BYTEEN = 1 << ADDRESS[1:0].
  - SH: halfword replicated; BYTEEN = ADDRESS[1] ? 1100 : 0011.
  - SW: data unchanged; BYTEEN = 1111.
- Load extraction:
  - Select the lane by the registered ADDRESS[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Reads drive MEM_BYTEEN = 1111.
- READ_DATA holds its value after DONE until the next load completes.
- READ_DATA is unchanged by stores.
- An undefined load funct3 (011, 110, 111) is treated as LW.

Decomposition:
- Shared package holds:
  - Load funct3 codes.
  - Store size codes.
  - The READ_CTRL/WRITE_CTRL bit positions. The decoder uses the same package.
  - FSM state encodings.
- One combinational sub-module, mem_lane_align, does store steering, byte-enable generation and load extension/selection. The controller holds the FSM, registers and timeout counter.

Test Plan:
- SW at 0x0000_0010, data 0x1234_5678, ack after 3 cycles:
  - MEM_ADDRESS=0x4, BYTEEN=1111, MEM_WRITEDATA=0x12345678.
  - BUSYWAIT high for 4 cycles, then low for 1.
- SB at 0x13, data 0xAB:
  - BYTEEN=1000, MEM_WRITEDATA=0xABABABAB.
- LB at 0x02, MEM_READDATA=0x0080_0000:
  - READ_DATA=0xFFFF_FF80.
  - LBU on the same inputs gives READ_DATA=0x0000_0080.
- LH at 0x03:
  - No MEM_READ/MEM_WRITE strobe.
  - MISALIGNED=1 and READ_DATA=0 in the single BUSYWAIT-low cycle.
- ACK_TIMEOUT=4, LW with no ack:
  - TIMEOUT_ERR=1, READ_DATA=0, strobes drop.
  - Then a new LW with an immediate ack completes normally with flags cleared.
- RESET asserted during ACCESS:
  - Next edge: all outputs 0, state IDLE.
  - A late MEM_ACK is ignored.
